// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI memory initiator.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_WIDTH = 7;
  localparam int DATA_WIDTH = 8;

  localparam logic RW_READ = 1'b1;

  // Gray-ordered so every legal transition flips a single bit.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LEAD  = 2'b01,
    SHIFT = 2'b11,
    TRAIL = 2'b10
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer for the SPI clock; emits rise/fall strobes on the edge
// where sclk changes. Counter and phase are held at zero while en is low.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap      = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = wrap && !sclk;
  assign fall_tick = wrap && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one {addr, rw, data} frame per start, MSB first.
// state | meaning
// IDLE  | cs_n high, waiting for start
// LEAD  | cs_n low, one half-period before the first sclk rise
// SHIFT | 16 sclk periods; sample miso on rise, advance mosi on fall
// TRAIL | sclk low, cs_n held low for one half-period, then done
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = spi_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = spi_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rw,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int FW = ADDR_WIDTH + 1 + DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_LEAD  = LEAD;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_TRAIL = TRAIL;

  logic [1:0]            state;
  logic [FW-1:0]         frame_in;
  logic [FW-2:0]         tx;
  logic [DATA_WIDTH-1:0] rx;
  logic [4:0]            bit_cnt;
  logic                  rw_q;
  logic                  rise_tick;
  logic                  fall_tick;
  logic                  gen_sclk;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state != ST_IDLE),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .sclk     (gen_sclk)
  );

  // The generator keeps running through TRAIL to time it; only SHIFT shows sclk.
  assign sclk = gen_sclk && (state == ST_SHIFT);

  always_comb begin
    frame_in = {addr, rw, wdata};
    if (rw == RW_READ) frame_in[DATA_WIDTH-1:0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      rw_q    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tx      <= frame_in[FW-2:0];
            mosi    <= frame_in[FW-1];
            rw_q    <= rw;
            bit_cnt <= '0;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (rise_tick) begin
            rx      <= {rx[DATA_WIDTH-2:0], miso};
            bit_cnt <= bit_cnt + 5'd1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rise_tick) begin
            rx      <= {rx[DATA_WIDTH-2:0], miso};
            bit_cnt <= bit_cnt + 5'd1;
          end else if (fall_tick) begin
            if (bit_cnt == 5'(FW)) begin
              mosi  <= 1'b0;
              state <= ST_TRAIL;
            end else begin
              mosi <= tx[FW-2];
              tx   <= {tx[FW-3:0], 1'b0};
            end
          end
        end
        ST_TRAIL: begin
          if (rise_tick) begin
            cs_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (rw_q == RW_READ) rdata <= rx;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a CLK_DIV=4 and a CLK_DIV=1 instance, each talking to
// a behavioural SPI responder; frames are checked against arithmetic expectations.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n;

  logic       start [2];
  logic [6:0] addr  [2];
  logic       rw    [2];
  logic [7:0] wdata [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] rdata [2];
  logic       sclk  [2];
  logic       cs_n  [2];
  logic       mosi  [2];
  logic       miso  [2] = '{1'b0, 1'b0};

  int checks = 0;
  int errors = 0;

  // Responder / monitor state, owned by the monitor process.
  int          cyc        = 0;
  logic [15:0] mosi_cap  [2] = '{16'h0, 16'h0};
  int          rise_cnt  [2] = '{0, 0};
  int          first_rise[2] = '{0, 0};
  int          last_rise [2] = '{0, 0};
  int          gap_bad   [2] = '{0, 0};
  int          bad_edge  [2] = '{0, 0};
  int          done_cnt  [2] = '{0, 0};
  int          bitpos    [2] = '{0, 0};
  logic        cs_prev   [2] = '{1'b1, 1'b1};
  logic        sclk_prev [2] = '{1'b0, 1'b0};

  // Written only by the stimulus tasks.
  logic [15:0] resp_word [2];
  logic [7:0]  exp_rdata [2];

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .addr(addr[0]), .rw(rw[0]),
    .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .addr(addr[1]), .rw(rw[1]),
    .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  function automatic int cdv(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [15:0] model_frame(input logic [6:0] a, input logic r,
                                              input logic [7:0] w);
    int v;
    v = int'(a) * 512 + int'(r) * 256 + (r ? 0 : int'(w));
    return 16'(v);
  endfunction

  // Mode-0 responder: first bit on cs_n fall, next bit after each sclk fall,
  // capture mosi on each sclk rise.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (done[d] === 1'b1) done_cnt[d]++;
      if (cs_prev[d] && !cs_n[d]) begin
        mosi_cap[d] = '0;
        rise_cnt[d] = 0;
        gap_bad[d]  = 0;
        bitpos[d]   = 15;
        miso[d]     = resp_word[d][15];
      end
      if (!sclk_prev[d] && sclk[d]) begin
        if (cs_n[d]) bad_edge[d]++;
        if (rise_cnt[d] > 0 && (cyc - last_rise[d]) != 2 * cdv(d)) gap_bad[d]++;
        if (rise_cnt[d] == 0) first_rise[d] = cyc;
        last_rise[d] = cyc;
        mosi_cap[d]  = {mosi_cap[d][14:0], mosi[d]};
        rise_cnt[d]++;
      end
      if (sclk_prev[d] && !sclk[d]) begin
        bitpos[d]--;
        miso[d] = (bitpos[d] >= 0) ? resp_word[d][bitpos[d]] : 1'b0;
      end
      cs_prev[d]   = cs_n[d];
      sclk_prev[d] = sclk[d];
    end
  end

  // Shared end-of-frame checks, reached once done has been observed.
  task automatic check_end(input int d, input int t0, input int base,
                           input logic [15:0] exp_frame, input logic [7:0] exp_rd,
                           input string tag);
    checks++;
    if ((cyc - t0) !== 33 * cdv(d)) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, cyc - t0, 33 * cdv(d));
    end
    checks++;
    if (busy[d] !== 1'b0 || cs_n[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s end_state: busy=%b cs_n=%b want busy=0 cs_n=1", tag, busy[d], cs_n[d]);
    end
    checks++;
    if (mosi_cap[d] !== exp_frame) begin
      errors++;
      $display("FAIL %s mosi_frame: got %h want %h", tag, mosi_cap[d], exp_frame);
    end
    checks++;
    if (rise_cnt[d] !== 16 || gap_bad[d] !== 0 || bad_edge[d] !== 0) begin
      errors++;
      $display("FAIL %s sclk_edges: rises=%0d gap_err=%0d stray=%0d want 16/0/0",
               tag, rise_cnt[d], gap_bad[d], bad_edge[d]);
    end
    checks++;
    if ((first_rise[d] - t0) !== cdv(d)) begin
      errors++;
      $display("FAIL %s first_rise: got T0+%0d want T0+%0d", tag, first_rise[d] - t0, cdv(d));
    end
    checks++;
    if (rdata[d] !== exp_rd) begin
      errors++;
      $display("FAIL %s rdata: got %h want %h", tag, rdata[d], exp_rd);
    end
    checks++;
    if ((done_cnt[d] - base) !== 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d want 1", tag, done_cnt[d] - base);
    end
  endtask

  task automatic run_frame(input int d, input logic [6:0] a, input logic r,
                           input logic [7:0] w, input logic [15:0] resp,
                           input int poke, input string tag);
    logic [15:0] exp_frame;
    logic [7:0]  exp_rd;
    int          t0, base;
    bit          got;
    exp_frame    = model_frame(a, r, w);
    exp_rd       = r ? resp[7:0] : exp_rdata[d];
    resp_word[d] = resp;
    @(negedge clk);
    addr[d] = a; rw[d] = r; wdata[d] = w; start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    t0   = cyc;
    base = done_cnt[d];
    addr[d] = 7'($urandom); rw[d] = 1'($urandom); wdata[d] = 8'($urandom);
    checks++;
    if (busy[d] !== 1'b1 || cs_n[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b cs_n=%b want 1/0", tag, busy[d], cs_n[d]);
    end
    got = 1'b0;
    for (int i = 0; i < 40 * cdv(d) + 10; i++) begin
      @(negedge clk);
      start[d] = (poke > 0 && (cyc - t0) == poke - 1);
      if (done[d] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    start[d] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, 40 * cdv(d) + 10);
    end else begin
      check_end(d, t0, base, exp_frame, exp_rd, tag);
    end
    exp_rdata[d] = exp_rd;
    @(negedge clk);
    checks++;
    if (done[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: done=%b one cycle later, want 0", tag, done[d]);
    end
    if (poke > 0) begin
      repeat (4) @(negedge clk);
      checks++;
      if (cs_n[d] !== 1'b1 || busy[d] !== 1'b0 || (done_cnt[d] - base) !== 1) begin
        errors++;
        $display("FAIL %s not_queued: cs_n=%b busy=%b dones=%0d want 1/0/1",
                 tag, cs_n[d], busy[d], done_cnt[d] - base);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; addr[d] = '0; rw[d] = 1'b0; wdata[d] = '0;
      resp_word[d] = '0; exp_rdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cs_n[d] !== 1'b1 || sclk[d] !== 1'b0 || mosi[d] !== 1'b0 ||
          busy[d] !== 1'b0 || done[d] !== 1'b0 || rdata[d] !== 8'h00) begin
        errors++;
        $display("FAIL reset_values d%0d: cs_n=%b sclk=%b mosi=%b busy=%b done=%b rdata=%h want 1/0/0/0/0/00",
                 d, cs_n[d], sclk[d], mosi[d], busy[d], done[d], rdata[d]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    run_frame(0, 7'h15, 1'b0, 8'hA5, 16'h1234, 0, "write");
  endtask

  task automatic test_read;
    run_frame(0, 7'h15, 1'b1, 8'h77, 16'h003C, 0, "read");
  endtask

  task automatic test_clkdiv1;
    run_frame(1, 7'h55, 1'b1, 8'h00, 16'h00FF, 0, "div1_read");
    run_frame(1, 7'h2A, 1'b0, 8'h81, 16'hFFFF, 0, "div1_write");
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      run_frame(i % 2, 7'($urandom), 1'($urandom), 8'($urandom), 16'($urandom), 0, "random");
    end
  endtask

  task automatic test_ignored_start;
    run_frame(0, 7'h4B, 1'b0, 8'hC6, 16'h0000, 20, "ignored_start");
  endtask

  task automatic test_back_to_back;
    logic [15:0] f1, f2;
    int          t0, base;
    bit          got;
    f1 = model_frame(7'h41, 1'b0, 8'h5A);
    f2 = model_frame(7'h0F, 1'b1, 8'h00);
    resp_word[0] = 16'hAAAA;
    @(negedge clk);
    addr[0] = 7'h41; rw[0] = 1'b0; wdata[0] = 8'h5A; start[0] = 1'b1;
    @(negedge clk);
    t0 = cyc; base = done_cnt[0];
    addr[0] = 7'h0F; rw[0] = 1'b1; wdata[0] = 8'h33;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_first timeout: no done within 200 cycles");
    end else begin
      check_end(0, t0, base, f1, exp_rdata[0], "b2b_first");
    end
    resp_word[0] = 16'h5599;
    @(negedge clk);
    checks++;
    if (cs_n[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: cs_n=%b busy=%b one cycle after done, want 0/1", cs_n[0], busy[0]);
    end
    start[0] = 1'b0;
    t0 = cyc; base = done_cnt[0];
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_second timeout: no done within 200 cycles");
    end else begin
      check_end(0, t0, base, f2, 8'h99, "b2b_second");
    end
    exp_rdata[0] = 8'h99;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int  base;
    bit  got;
    resp_word[0] = 16'hF0F0;
    @(negedge clk);
    addr[0] = 7'h7E; rw[0] = 1'b1; wdata[0] = 8'h00; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rise_cnt[0] == 6) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL reset_mid timeout: bit 5 never reached");
    end
    base = done_cnt[0];
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0 || busy[0] !== 1'b0 || mosi[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: cs_n=%b sclk=%b busy=%b mosi=%b want 1/0/0/0",
               cs_n[0], sclk[0], busy[0], mosi[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ((done_cnt[0] - base) !== 0 || rdata[0] !== 8'h00 || cs_n[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_nodone: dones=%0d rdata=%h cs_n=%b want 0/00/1",
               done_cnt[0] - base, rdata[0], cs_n[0]);
    end
    run_frame(0, 7'h3A, 1'b1, 8'h00, 16'h00E7, 0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_clkdiv1;
    test_random;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
